uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have: rx_busy  input  1  frame in progress, from uart_rx.
REQ-004 SHALL have: rx_done  input  1  one-cycle frame-complete strobe, from uart_rx.
REQ-005 SHALL have: rx_error  input  1  parity/stop error of the completing frame, valid with rx_done.
REQ-006 SHALL have: rx_data  input  8  received word, valid with rx_done.
REQ-007 SHALL have: num_data_bits  output  4; stop_bits  output  stop_bits_t; parity  output  parity_t; active config driven to uart_rx.
REQ-008 SHALL have: cfg_wr  input  1  config write strobe; cfg_num_data_bits  input  4; cfg_stop_bits  input  stop_bits_t; cfg_parity  input  parity_t.
REQ-009 SHALL have: cfg_pending  output  1  accepted config not yet applied; cfg_err  output  1  one-cycle reject pulse.
REQ-010 SHALL have: out_valid  output  1; out_ready  input  1; out_data  output  8; out_error  output  1; FIFO head, valid/ready stream.
REQ-011 SHALL have: fifo_count  output  4  entries held (0..8); overflow  output  1  sticky; drop_count  output  8  saturating; clr_status  input  1.

Function
REQ-012 SHALL hold an 8-entry FIFO of {error, data[7:0]}; out_* SHALL present the head combinationally from storage, out_valid = (fifo_count != 0).
REQ-013 On rx_done with FIFO not full (or full with same-cycle pop), SHALL push {rx_error, rx_data masked to num_data_bits LSBs, upper bits 0}; visible on out_valid next cycle.
REQ-014 Pop SHALL occur when out_valid && out_ready; simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo 8.
REQ-015 rx_done while full and no pop SHALL drop the frame, set overflow, increment drop_count saturating at 255.
REQ-016 clr_status SHALL clear overflow and drop_count next cycle; a same-cycle drop SHALL win (overflow=1, drop_count=1).
REQ-017 Config FSM states: IDLE, BUSY, APPLY. IDLE->BUSY on rx_busy=1; BUSY->IDLE on rx_busy=0 with no pending config; BUSY->APPLY on rx_busy=0 with pending; APPLY->IDLE after one cycle.
REQ-018 cfg_wr with cfg_num_data_bits in 5..8 SHALL latch into a shadow register and set cfg_pending; outside 5..8 SHALL pulse cfg_err next cycle and leave shadow unchanged.
REQ-019 Shadow SHALL be copied to active outputs on the cycle after cfg_wr if state is IDLE and rx_busy=0, else in APPLY; cfg_pending SHALL clear on that copy.
REQ-020 A second cfg_wr while pending SHALL overwrite the shadow; only the last value is applied.
REQ-021 Active config SHALL never change while rx_busy=1.

Reset
REQ-022 On rst: FIFO empty, fifo_count=0, out_valid=0, overflow=0, drop_count=0, cfg_pending=0, cfg_err=0, state IDLE.
REQ-023 Reset active config SHALL be num_data_bits=8, stop_bits=STOP_BITS_1, parity=PARITY_EVEN.
REQ-024 rst mid-frame SHALL discard FIFO contents and pending config; rx_done in the reset cycle SHALL be ignored.

Configuration
REQ-025 Macro UART_RX_CTRL_ERR_DROP_EN: defined -> frames with rx_error=1 SHALL not be pushed, SHALL increment drop_count (saturating), SHALL not set overflow, out_error SHALL be tied 0; undefined -> errored frames pushed with out_error=1.

Verification
REQ-026 Reset, rx_done with rx_data=0xB1, rx_error=0 -> next cycle out_valid=1, out_data=0xB1, out_error=0, fifo_count=1.
REQ-027 num_data_bits=5, rx_done with rx_data=0xFF -> out_data=0x1F.
REQ-028 9 rx_done pulses, out_ready=0 -> fifo_count=8, overflow=1, drop_count=1; then clr_status -> overflow=0, drop_count=0.
REQ-029 cfg_wr(7, STOP_BITS_1, PARITY_EVEN) while rx_busy=1 -> cfg_pending=1, num_data_bits stays 8; rx_busy falls -> num_data_bits=7 one cycle later, cfg_pending=0.
REQ-030 cfg_wr with cfg_num_data_bits=4 -> cfg_err pulses one cycle, config unchanged.
REQ-031 rx_done with rx_error=1, data 0x55 -> macro undefined: out_error=1, out_data=0x55; defined: out_valid stays 0, drop_count=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 8-deep frame FIFO with overflow/drop status and a
// config shadow that is applied only between frames. Build option: UART_RX_CTRL_ERR_DROP_EN.
package uart_rx_ctrl_pkg;
  typedef enum logic [0:0] {STOP_BITS_1 = 1'b0, STOP_BITS_2 = 1'b1} stop_bits_t;
  typedef enum logic [1:0] {PARITY_NONE = 2'd0, PARITY_EVEN = 2'd1, PARITY_ODD = 2'd2} parity_t;
endpackage

module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_busy,
  input  logic       rx_done,
  input  logic       rx_error,
  input  logic [7:0] rx_data,
  output logic [3:0] num_data_bits,
  output stop_bits_t stop_bits,
  output parity_t    parity,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_num_data_bits,
  input  stop_bits_t cfg_stop_bits,
  input  parity_t    cfg_parity,
  output logic       cfg_pending,
  output logic       cfg_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_error,
  output logic [3:0] fifo_count,
  output logic       overflow,
  output logic [7:0] drop_count,
  input  logic       clr_status
);

`ifdef UART_RX_CTRL_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, APPLY} state_t;

  // ---------------- frame FIFO ----------------
  logic [8:0] mem [8];
  logic [2:0] wr_ptr, rd_ptr;
  logic [8:0] head;
  logic [7:0] data_mask;
  logic       full, push, pop, err_drop, ovf_drop, drop;

  assign head       = mem[rd_ptr];
  assign out_valid  = (fifo_count != 4'd0);
  assign out_data   = head[7:0];
  assign out_error  = ERR_DROP ? 1'b0 : head[8];
  assign full       = (fifo_count == 4'd8);
  assign pop        = out_valid && out_ready;
  assign data_mask  = 8'hFF >> (4'd8 - num_data_bits);
  assign err_drop   = ERR_DROP && rx_done && rx_error;
  // A same-cycle pop frees the slot, so a full FIFO can still accept the frame.
  assign push       = rx_done && !err_drop && (!full || pop);
  assign ovf_drop   = rx_done && !err_drop && full && !pop;
  assign drop       = ovf_drop || err_drop;

  // NOTE: storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rx_error, rx_data & data_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      fifo_count <= fifo_count + {3'b0, push} - {3'b0, pop};
      // A drop in the clearing cycle is counted as the first event after the clear.
      if (drop) begin
        if (clr_status) begin
          overflow   <= ovf_drop;
          drop_count <= 8'd1;
        end else begin
          overflow   <= overflow | ovf_drop;
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
      end else if (clr_status) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  // ---------------- config shadow / apply FSM ----------------
  state_t     state;
  logic [3:0] sh_num_data_bits;
  stop_bits_t sh_stop_bits;
  parity_t    sh_parity;
  logic       cfg_ok, apply_now;

  assign cfg_ok    = (cfg_num_data_bits >= 4'd5) && (cfg_num_data_bits <= 4'd8);
  // Copy only while the receiver is quiet: straight from IDLE, or on BUSY->APPLY.
  assign apply_now = cfg_pending && !rx_busy && (state != APPLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      num_data_bits    <= 4'd8;
      stop_bits        <= STOP_BITS_1;
      parity           <= PARITY_EVEN;
      sh_num_data_bits <= 4'd8;
      sh_stop_bits     <= STOP_BITS_1;
      sh_parity        <= PARITY_EVEN;
      cfg_pending      <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
      if (apply_now) begin
        num_data_bits <= sh_num_data_bits;
        stop_bits     <= sh_stop_bits;
        parity        <= sh_parity;
        cfg_pending   <= 1'b0;
      end
      // A fresh write in the apply cycle stays pending for the next opportunity.
      if (cfg_wr && cfg_ok) begin
        sh_num_data_bits <= cfg_num_data_bits;
        sh_stop_bits     <= cfg_stop_bits;
        sh_parity        <= cfg_parity;
        cfg_pending      <= 1'b1;
      end
      case (state)
        IDLE:    if (rx_busy) state <= BUSY;
        BUSY:    if (!rx_busy) state <= cfg_pending ? APPLY : IDLE;
        APPLY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
